// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {remainder, quotient}; one quotient bit per cycle on operand magnitudes.
module div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign dvd_neg = signed_div & dividend[WIDTH-1];
  assign dvs_neg = signed_div & divisor[WIDTH-1];

  // quo_q holds the not-yet-consumed dividend bits; its MSB shifts into the remainder.
  assign trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      StFree: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start && !annul) begin
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          quo_d     = dvd_neg ? -dividend : dividend;
          dvs_d     = dvs_neg ? -divisor : divisor;
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = (divisor == '0) ? StByZero : StOn;
        end
      end

      StByZero: begin
        result_d = '0;
        state_d  = StEnd;
      end

      StOn: begin
        if (annul || !start) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = StFree;
        end else if (cnt_q == CntLast) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = StEnd;
        end else begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
          end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          end
          quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d = cnt_q + 1'b1;
        end
      end

      StEnd: begin
        // A new request needs start to drop for a cycle first.
        if (annul || !start) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = StFree;
        end else begin
          ready_d = 1'b1;
        end
      end

      default: begin
        result_d = '0;
        ready_d  = 1'b0;
        state_d  = StFree;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, aborts and randomized operands
// against a truncating-division reference model.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          signed_div;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          start;
  logic          annul;
  logic [2*W-1:0] result;
  logic          ready;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .start      (start),
    .annul      (annul),
    .result     (result),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  // Mathematical truncating division on magnitudes, then sign rules; zero divisor gives 0.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ma, mb, q, r;
    logic na, nb;
    logic [31:0] qo, ro;
    if (b == 32'h0) return 64'h0;
    na = s && a[31];
    nb = s && b[31];
    ma = na ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
    mb = nb ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
    q  = ma / mb;
    r  = ma % mb;
    qo = q[31:0];
    ro = r[31:0];
    if (na != nb) qo = -qo;
    if (na) ro = -ro;
    return {ro, qo};
  endfunction

  // Present a request; returns just after the edge that samples it.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    signed_div = s;
    dividend   = a;
    divisor    = b;
    annul      = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
  endtask

  // Edges after the sampling edge until ready is seen; -1 if never within the budget.
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_op();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", ready);
    end
    checks++;
    if (result !== 64'h0) begin
      errors++; $display("FAIL reset_result: got %h expected 0", result);
    end
    rst = 1'b0;
  endtask

  logic        t_s [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] t_a [6] = '{32'd7, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'd9};
  logic [31:0] t_b [6] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'h10, 32'hFFFF_FFFF, 32'd3};
  logic [63:0] t_r [6] = '{64'h00000001_00000003, 64'hFFFFFFFF_FFFFFFFD,
                           64'h00000001_FFFFFFFD, 64'h0000000F_0FFFFFFF,
                           64'h00000000_80000000, 64'h00000000_00000003};

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(t_s[i], t_a[i], t_b[i]);
      wait_ready(lat);
      checks++;
      if (lat != 33) begin
        errors++; $display("FAIL dir%0d_latency: got %0d expected 33", i, lat);
      end
      checks++;
      if (result !== t_r[i]) begin
        errors++; $display("FAIL dir%0d_result: got %h expected %h", i, result, t_r[i]);
      end
      checks++;
      if (ref_div(t_s[i], t_a[i], t_b[i]) !== t_r[i]) begin
        errors++; $display("FAIL dir%0d_model: got %h expected %h", i,
                           ref_div(t_s[i], t_a[i], t_b[i]), t_r[i]);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b1 || result !== t_r[i]) begin
        errors++; $display("FAIL dir%0d_hold: got ready=%b result=%h expected 1 %h",
                           i, ready, result, t_r[i]);
      end
      release_op();
      checks++;
      if (ready !== 1'b0 || result !== 64'h0) begin
        errors++; $display("FAIL dir%0d_release: got ready=%b result=%h expected 0 0",
                           i, ready, result);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    issue(1'b0, 32'h1234, 32'h0);
    wait_ready(lat);
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL dz_latency: got %0d expected 2", lat);
    end
    checks++;
    if (result !== 64'h0) begin
      errors++; $display("FAIL dz_result: got %h expected 0", result);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || result !== 64'h0) begin
        errors++; $display("FAIL dz_hold%0d: got ready=%b result=%h expected 1 0",
                           k, ready, result);
      end
    end
    release_op();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL dz_release: got %b expected 0", ready);
    end
  endtask

  // Abort on the 10th ON cycle (annul or rst), then a new 9/3 request right away.
  task automatic test_abort(input bit use_rst);
    int lat;
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1;
    else annul = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    annul = 1'b0;
    checks++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      errors++; $display("FAIL abort%0d_cleared: got ready=%b result=%h expected 0 0",
                         use_rst, ready, result);
    end
    dividend = 32'd9;
    divisor  = 32'd3;
    @(posedge clk); #1;
    wait_ready(lat);
    checks++;
    if (lat != 33) begin
      errors++; $display("FAIL abort%0d_restart_latency: got %0d expected 33", use_rst, lat);
    end
    checks++;
    if (result !== 64'h00000000_00000003) begin
      errors++; $display("FAIL abort%0d_restart_result: got %h expected 0000000000000003",
                         use_rst, result);
    end
    release_op();
  endtask

  task automatic test_start_drop();
    int lat;
    issue(1'b1, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    wait_ready(lat);
    checks++;
    if (lat != -1 || result !== 64'h0) begin
      errors++; $display("FAIL start_drop: got lat=%0d result=%h expected -1 0", lat, result);
    end
  endtask

  task automatic test_start_annul_free();
    int lat;
    @(posedge clk); #1;
    signed_div = 1'b0; dividend = 32'd5; divisor = 32'd1;
    start = 1'b1; annul = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b0 || result !== 64'h0) begin
        errors++; $display("FAIL free_annul%0d: got ready=%b result=%h expected 0 0",
                           k, ready, result);
      end
    end
    annul = 1'b0;
    @(posedge clk); #1;
    wait_ready(lat);
    checks++;
    if (lat != 33 || result !== 64'h00000000_00000005) begin
      errors++; $display("FAIL free_annul_then_start: got lat=%0d result=%h expected 33 %h",
                         lat, result, 64'h5);
    end
    release_op();
  endtask

  task automatic test_operand_change();
    int lat;
    logic [63:0] exp;
    exp = ref_div(1'b1, 32'hFFFF_FF9C, 32'd7);
    issue(1'b1, 32'hFFFF_FF9C, 32'd7);
    signed_div = 1'b0; dividend = 32'd55; divisor = 32'd0;
    wait_ready(lat);
    checks++;
    if (lat != 33 || result !== exp) begin
      errors++; $display("FAIL operand_change: got lat=%0d result=%h expected 33 %h",
                         lat, result, exp);
    end
    release_op();
  endtask

  task automatic test_random();
    int lat, exp_lat;
    logic s;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom;
      endcase
      exp     = ref_div(s, a, b);
      exp_lat = (b == 32'h0) ? 2 : 33;
      issue(s, a, b);
      wait_ready(lat);
      checks++;
      if (lat != exp_lat || result !== exp) begin
        errors++; $display("FAIL rand%0d s=%b %h/%h: got lat=%0d result=%h expected %0d %h",
                           i, s, a, b, lat, result, exp_lat, exp);
      end
      release_op();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_abort(1'b0);
    test_abort(1'b1);
    test_start_drop();
    test_start_annul_free();
    test_operand_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the EX stage; executes MIPS DIV and DIVU.
- EX decodes `ex_alu_op`/`ex_alu_sel` from the ID/EX register, asserts `start`, and holds a pipeline stall request until `ready`.
- Produces `{remainder, quotient}` for the HI/LO write path.
- Radix-2 restoring algorithm over magnitudes, one quotient bit per cycle, with sign correction on completion.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high; 1 = reset.
- signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- dividend  in  WIDTH  operand A; sampled with start.
- divisor  in  WIDTH  operand B; sampled with start.
- start  in  1  request, level-sensitive; EX holds it high until ready is seen.
- annul  in  1  pipeline flush; aborts the operation in progress.
- result  out  2*WIDTH  [2W-1:W] = remainder, [W-1:0] = quotient.
- ready  out  1  result valid.

Behaviour:
- States: FREE, BY_ZERO, ON, END.
- Reset: state = FREE, cnt = 0, result = 0, ready = 0. Reset has priority in every state, including mid-ON.

FREE
- start=1 and annul=0: latch signed_div and operands.
  - divisor == 0 → BY_ZERO.
  - otherwise → ON, cnt = 0, partial remainder = 0.
- For signed operations, magnitudes are taken at latch time: two's-complement negate if the MSB is 1.
- start=1 and annul=1: stay in FREE. Annul wins.
- ready = 0 and result = 0 throughout FREE.

BY_ZERO
- Next edge → END, result = 0 (quotient 0, remainder 0).

ON
- annul=1 at any ON cycle → FREE; result = 0, ready = 0; the partial result is discarded.
- start dropping to 0 during ON is treated as an abort → FREE, same as annul.
- cnt < WIDTH: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial = rem − |divisor|, computed at WIDTH+1 bits.
  - If trial is non-negative, rem = trial and quo LSB = 1; otherwise quo LSB = 0.
  - cnt++.
- cnt == WIDTH: sign-fix, register result, set ready = 1 → END.
  - Signed quotient is negated if sign(dividend) XOR sign(divisor).
  - Signed remainder is negated if sign(dividend).
  - Unsigned: no fix.

END
- ready = 1, result is held stable.
- start=0 → FREE; next cycle ready = 0, result = 0.
- start still 1: remain in END. No restart without start first dropping for one cycle.
- annul in END → FREE.

Latency and operand rules:
- Start sampled at edge E0 with divisor ≠ 0: ready first visible after E0+33.
- Divide by zero: ready first visible after E0+2.
- Operand changes after E0 are ignored.
- Signed 0x80000000 / 0xFFFFFFFF: magnitude overflow wraps; quotient = 0x80000000, remainder = 0. No exception is raised.
- Arithmetic is modulo 2^WIDTH for the quotient.

Test Plan:
- DIVU 7 / 2: start held → after 33 cycles ready=1, result = {0x00000001, 0x00000003}; drop start → ready=0 next cycle, result=0.
- DIV −7 / 2 (0xFFFFFFF9 / 0x2) → result = {0xFFFFFFFF, 0xFFFFFFFD}.
- DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 0x1.
- DIVU 0xFFFFFFFF / 0x10 → quotient 0x0FFFFFFF, remainder 0xF.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide by zero: 0x1234 / 0 → ready after 2 cycles, result 0; holding start keeps END; dropping start returns to FREE.
- Annul on the 10th ON cycle → ready stays 0, result 0, state FREE.
  - A new start (9 / 3) immediately after → quotient 3, remainder 0 after 33 cycles.
  - Same abort when rst pulses mid-ON instead of annul.
- start and annul both 1 in FREE → no state change, ready 0.
- Operands changed after the start edge → result reflects the latched values.
